lsu_axil: RTL and testbench
===========================

Name: lsu_axil

Overview:
- Multi-cycle load/store stage between the execute result (address, store data, access attributes) and register writeback.
- Turns one memory request per instruction into an AXI4-Lite master transaction.
- Aligns loads by byte lane and sign- or zero-extends them; shifts and strobes stores.
- Uses valid/ready handshakes on both sides, so the core advances its PC only when writeback data is valid.

Parameters:
ADDR_W, 32, address width; data path is fixed at 32 bits.
RDY_RESET, 1, value of in_ready while in IDLE (1 = accept immediately).

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  synchronous, active-low reset (0 = reset, sampled on posedge clk)
in_valid  input  1  request valid from execute
in_ready  output  1  block can accept a request
ren  input  1  load request
wen  input  1  store request
size  input  2  00 byte, 01 half, 10 word, 11 illegal
is_signed  input  1  sign-extend load result
addr  input  ADDR_W  byte address (exu result)
wdata  input  32  store data, LSB-justified (rsb)
out_valid  output  1  result valid to writeback
out_ready  input  1  writeback consumes result
rdata  output  32  extended load data (0 for stores and no-ops)
err  output  1  access fault (misaligned, illegal, or bus error), valid with out_valid
araddr  output  ADDR_W  word-aligned read address
arvalid  output  1
arready  input  1
rdata_bus  input  32
rresp  input  2
rvalid  input  1
rready  output  1
awaddr  output  ADDR_W  word-aligned write address
awvalid  output  1
awready  input  1
wdata_bus  output  32
wstrb  output  4
wvalid  output  1
wready  input  1
bresp  input  2
bvalid  input  1
bready  output  1

Behaviour:
- States: IDLE, RADDR, RDATA, WREQ, WRESP, DONE.
- Reset (rst==0 at posedge, regardless of state):
  - State goes to IDLE.
  - arvalid, rready, awvalid, wvalid, bready, out_valid, err all 0; rdata = 0.
  - Outstanding bus transactions are abandoned; the slave shares the reset.
- in_ready = RDY_RESET && state==IDLE.
- Request acceptance (in_valid && in_ready): addr, wdata, size, is_signed, ren, wen are latched.
- Fault check at acceptance; the result is only err=1 and rdata=0, with no bus traffic, and the next state is DONE. Fault conditions:
  - ren && wen
  - size==11 with ren or wen set
  - half access with addr[0]==1
  - word access with addr[1:0]!=0
- Neither ren nor wen: next state DONE, err=0, rdata=0, no bus traffic.
- Load path:
  - RADDR: arvalid=1, araddr = addr & ~3; hold until arready, then go to RDATA.
  - RDATA: rready=1 until rvalid.
  - On the rvalid cycle, capture rdata_bus >> (8*addr[1:0]), mask to 8/16/32 bits, extend per is_signed; err = (rresp!=0). Go to DONE.
- Store path:
  - WREQ: awvalid and wvalid rise together.
    - awaddr = addr & ~3.
    - wdata_bus = wdata << (8*addr[1:0]).
    - wstrb = {0001, 0011, 1111}[size] << addr[1:0].
  - Each valid drops independently after its own handshake. Simultaneous awready and wready are allowed and complete both.
  - When both handshakes are done, go to WRESP: bready=1 until bvalid; err = (bresp!=0). Go to DONE.
- DONE:
  - out_valid=1; rdata and err are held stable until out_ready.
  - On the out_valid && out_ready cycle: next state IDLE, out_valid=0. No new request is accepted in that same cycle.
- Bus outputs do not change while their valid is high and ready is low.
- Minimum latency with zero-wait slave (ready/valid high in the first offered cycle):
  - Load: accept at T0, ar handshake T1, r handshake T2, out_valid at T3.
  - Store: out_valid at T3.
  - Fault or no-op: out_valid at T1.
- No timeout: a stalled slave stalls the block indefinitely.

Test Plan:
- Reset: hold rst=0 for 2 cycles mid-RDATA -> all valids 0, in_ready=1, out_valid=0 after release.
- Load byte signed: addr=0x80000003, size=00, is_signed=1, bus word 0x80FF1234 -> araddr=0x80000000, rdata=0xFFFFFF80, err=0, out_valid at T3.
- Load half unsigned: addr=0x80000002, size=01, bus word 0xBEEF0000 -> rdata=0x0000BEEF.
- Store half: addr=0x80000006, wdata=0x0000ABCD, awready delayed 3 cycles after wready -> wstrb=1100, wdata_bus=0xABCD0000, awaddr=0x80000004, single aw and single w handshake, out_valid one cycle after bvalid.
- Faults:
  - Word load at addr=0x80000001 -> no arvalid, err=1, out_valid at T1.
  - bresp=2'b10 on a valid store -> err=1.
- Backpressure: out_ready=0 for 4 cycles in DONE -> rdata, err, out_valid stable and in_ready=0 throughout; IDLE the cycle after out_ready=1.

Source files
------------

// File: rtl/lsu_axil.sv
// Load/store stage: turns one execute-stage memory request into a single AXI4-Lite
// read or write, aligning/extending loads and shifting/strobing stores.
module lsu_axil #(
  parameter int ADDR_W    = 32,
  parameter bit RDY_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              ren,
  input  logic              wen,
  input  logic [1:0]        size,
  input  logic              is_signed,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       rdata,
  output logic              err,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [31:0]       rdata_bus,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [31:0]       wdata_bus,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RADDR = 3'd1;
  localparam logic [2:0] S_RDATA = 3'd2;
  localparam logic [2:0] S_WREQ  = 3'd3;
  localparam logic [2:0] S_WRESP = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [1:0]        r_size;
  logic              r_signed;
  logic              r_aw_done;
  logic              r_w_done;
  logic [31:0]       r_rdata;
  logic              r_err;

  logic        w_accept;
  logic        w_access;
  logic        w_fault;
  logic        w_aw_fin;
  logic        w_w_fin;
  logic [4:0]  w_shamt;
  logic [31:0] w_shifted;
  logic [31:0] w_load;
  logic [3:0]  w_strb_base;

  assign in_ready = RDY_RESET && (r_state == S_IDLE);
  assign w_accept = in_valid && in_ready;
  assign w_access = ren || wen;
  assign w_fault  = (ren && wen) ||
                    (w_access && ((size == 2'b11) ||
                                  (size == 2'b01 && addr[0]) ||
                                  (size == 2'b10 && addr[1:0] != 2'b00)));

  // Bus valids derive from state and per-channel done flags, so they stay stable under stall.
  assign arvalid   = (r_state == S_RADDR);
  assign rready    = (r_state == S_RDATA);
  assign awvalid   = (r_state == S_WREQ) && !r_aw_done;
  assign wvalid    = (r_state == S_WREQ) && !r_w_done;
  assign bready    = (r_state == S_WRESP);
  assign out_valid = (r_state == S_DONE);
  assign rdata     = r_rdata;
  assign err       = r_err;

  assign araddr    = {r_addr[ADDR_W-1:2], 2'b00};
  assign awaddr    = {r_addr[ADDR_W-1:2], 2'b00};
  assign w_shamt   = {r_addr[1:0], 3'b000};
  assign wdata_bus = r_wdata << w_shamt;
  assign wstrb     = w_strb_base << r_addr[1:0];
  assign w_shifted = rdata_bus >> w_shamt;

  assign w_aw_fin  = r_aw_done || (awvalid && awready);
  assign w_w_fin   = r_w_done  || (wvalid && wready);

  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    w_strb_base = 4'b1111;
    w_load      = w_shifted;
    case (r_size)
      2'b00: begin
        w_strb_base = 4'b0001;
        w_load      = {{24{r_signed & w_shifted[7]}}, w_shifted[7:0]};
      end
      2'b01: begin
        w_strb_base = 4'b0011;
        w_load      = {{16{r_signed & w_shifted[15]}}, w_shifted[15:0]};
      end
      default: ;
    endcase
  end

  // NOTE: request latches carry no reset; they are only read after an acceptance loads them.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr   <= addr;
      r_wdata  <= wdata;
      r_size   <= size;
      r_signed <= is_signed;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst) begin
      r_state   <= S_IDLE;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_rdata   <= 32'd0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_rdata   <= 32'd0;
          r_err     <= 1'b0;
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
          if (w_fault) begin
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else if (ren) begin
            r_state <= S_RADDR;
          end else if (wen) begin
            r_state <= S_WREQ;
          end else begin
            r_state <= S_DONE;
          end
        end
        S_RADDR: if (arready) r_state <= S_RDATA;
        S_RDATA: if (rvalid) begin
          r_rdata <= w_load;
          r_err   <= (rresp != 2'b00);
          r_state <= S_DONE;
        end
        S_WREQ: begin
          if (awvalid && awready) r_aw_done <= 1'b1;
          if (wvalid && wready)   r_w_done  <= 1'b1;
          if (w_aw_fin && w_w_fin) r_state  <= S_WRESP;
        end
        S_WRESP: if (bvalid) begin
          r_err   <= (bresp != 2'b00);
          r_state <= S_DONE;
        end
        S_DONE: if (out_ready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_axil.sv
// Bench for lsu_axil: a delay-configurable AXI4-Lite slave plus an arithmetic
// reference model of alignment, extension, strobes, faults and latency.
module tb_lsu_axil;

  logic        clk, rst;
  logic        in_valid, in_ready, ren, wen, is_signed;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        out_valid, out_ready, err;
  logic [31:0] rdata;
  logic [31:0] araddr, awaddr, rdata_bus, wdata_bus;
  logic        arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready;
  logic        bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;

  int total = 0;
  int bad   = 0;

  lsu_axil #(.ADDR_W(32), .RDY_RESET(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .ren(ren), .wen(wen), .size(size), .is_signed(is_signed),
    .addr(addr), .wdata(wdata),
    .out_valid(out_valid), .out_ready(out_ready), .rdata(rdata), .err(err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata_bus(rdata_bus), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata_bus(wdata_bus), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observations of the last transaction
  int          obs_lat, obs_unstable, obs_ar_hs, obs_r_hs, obs_aw_hs, obs_w_hs, obs_b_hs;
  bit          obs_timeout, obs_idle_after, obs_bus, obs_accept;
  logic [31:0] obs_rdata, obs_araddr, obs_awaddr, obs_wdata_bus;
  logic        obs_err;
  logic [3:0]  obs_wstrb;

  // Model expectations
  int          exp_lat;
  logic [31:0] exp_rdata, exp_addr, exp_wd;
  logic [3:0]  exp_ws;
  logic        exp_err;
  logic [19:0] exp_hs;

  task automatic model(input logic m_ren, input logic m_wen, input logic [1:0] m_size,
                       input logic m_sgn, input logic [31:0] m_addr, input logic [31:0] m_wdata,
                       input logic [31:0] m_bus, input logic [1:0] m_resp,
                       input int ar_d, input int r_d, input int aw_d, input int w_d, input int b_d);
    int n, off;
    longint unsigned v, lim;
    bit fault;
    n     = (m_size == 2'd0) ? 1 : (m_size == 2'd1) ? 2 : 4;
    off   = int'(m_addr % 4);
    fault = (m_ren && m_wen) || ((m_ren || m_wen) && (m_size == 2'd3 || (off % n) != 0));
    exp_addr = m_addr - 32'(off);
    exp_wd = 32'd0; exp_ws = 4'd0; exp_rdata = 32'd0; exp_err = 1'b0; exp_hs = 20'd0;
    if (fault) begin
      exp_err = 1'b1;
      exp_lat = 1;
    end else if (m_ren) begin
      lim = 64'd1 << (8 * n);
      v   = ({32'd0, m_bus} >> (8 * off)) % lim;
      if (m_sgn && v >= lim / 2) v = v + 64'h1_0000_0000 - lim;
      exp_rdata = v[31:0];
      exp_err   = (m_resp != 2'd0);
      exp_lat   = 3 + ar_d + r_d;
      exp_hs    = {4'd1, 4'd1, 4'd0, 4'd0, 4'd0};
    end else if (m_wen) begin
      v       = {32'd0, m_wdata} << (8 * off);
      exp_wd  = v[31:0];
      exp_ws  = 4'(((1 << n) - 1) << off);
      exp_err = (m_resp != 2'd0);
      exp_lat = 3 + ((aw_d > w_d) ? aw_d : w_d) + b_d;
      exp_hs  = {4'd0, 4'd0, 4'd1, 4'd1, 4'd1};
    end else begin
      exp_lat = 1;
    end
  endtask

  task automatic clear_bus_inputs;
    arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0; out_ready = 0;
    rdata_bus = 32'd0; rresp = 2'd0; bresp = 2'd0;
  endtask

  // Issues one request and plays the slave / writeback side; only records observations.
  task automatic run_op(input logic o_ren, input logic o_wen, input logic [1:0] o_size,
                        input logic o_sgn, input logic [31:0] o_addr, input logic [31:0] o_wdata,
                        input logic [31:0] bus_word, input logic [1:0] resp,
                        input int ar_d, input int r_d, input int aw_d, input int w_d,
                        input int b_d, input int out_d);
    int cyc, ar_c, r_c, aw_c, w_c, b_c, o_c;
    bit done, hold_ar, hold_aw, hold_w;
    logic [31:0] p_araddr, p_awaddr, p_wd;
    logic [3:0]  p_ws;
    obs_lat = -1; obs_unstable = 0; obs_ar_hs = 0; obs_r_hs = 0; obs_aw_hs = 0;
    obs_w_hs = 0; obs_b_hs = 0; obs_timeout = 0; obs_idle_after = 0; obs_bus = 0;
    obs_rdata = 32'hx; obs_err = 1'bx; obs_araddr = 32'hx; obs_awaddr = 32'hx;
    obs_wdata_bus = 32'hx; obs_wstrb = 4'hx;
    ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0; o_c = 0; done = 0;
    hold_ar = 0; hold_aw = 0; hold_w = 0;
    p_araddr = 0; p_awaddr = 0; p_wd = 0; p_ws = 0;
    @(negedge clk);
    clear_bus_inputs();
    in_valid = 1; ren = o_ren; wen = o_wen; size = o_size; is_signed = o_sgn;
    addr = o_addr; wdata = o_wdata;
    obs_accept = in_ready;
    @(negedge clk);
    in_valid = 0; ren = $urandom; wen = $urandom; addr = $urandom; wdata = $urandom;
    cyc = 1;
    while (!done && cyc < 300) begin
      clear_bus_inputs();
      rdata_bus = $urandom; rresp = 2'($urandom); bresp = 2'($urandom);
      if (in_ready) obs_unstable++;
      if (arvalid || rready || awvalid || wvalid || bready) obs_bus = 1;
      if (hold_ar && (!arvalid || araddr !== p_araddr)) obs_unstable++;
      if (hold_aw && (!awvalid || awaddr !== p_awaddr)) obs_unstable++;
      if (hold_w && (!wvalid || wdata_bus !== p_wd || wstrb !== p_ws)) obs_unstable++;
      hold_ar = 0; hold_aw = 0; hold_w = 0;
      if (arvalid) begin
        arready = (ar_c >= ar_d); ar_c++; p_araddr = araddr;
        if (arready) begin obs_ar_hs++; obs_araddr = araddr; end else hold_ar = 1;
      end
      if (rready) begin
        rvalid = (r_c >= r_d); r_c++;
        if (rvalid) begin rdata_bus = bus_word; rresp = resp; obs_r_hs++; end
      end
      if (awvalid) begin
        awready = (aw_c >= aw_d); aw_c++; p_awaddr = awaddr;
        if (awready) begin obs_aw_hs++; obs_awaddr = awaddr; end else hold_aw = 1;
      end
      if (wvalid) begin
        wready = (w_c >= w_d); w_c++; p_wd = wdata_bus; p_ws = wstrb;
        if (wready) begin obs_w_hs++; obs_wdata_bus = wdata_bus; obs_wstrb = wstrb; end
        else hold_w = 1;
      end
      if (bready) begin
        bvalid = (b_c >= b_d); b_c++;
        if (bvalid) begin bresp = resp; obs_b_hs++; end
      end
      if (out_valid) begin
        if (o_c == 0) begin
          obs_lat = cyc; obs_rdata = rdata; obs_err = err;
        end else if (rdata !== obs_rdata || err !== obs_err) begin
          obs_unstable++;
        end
        out_ready = (o_c >= out_d); o_c++;
        if (out_ready) done = 1;
      end else if (o_c > 0) begin
        obs_unstable++;
      end
      @(negedge clk);
      cyc++;
    end
    clear_bus_inputs();
    if (!done) obs_timeout = 1;
    else obs_idle_after = in_ready && !out_valid;
  endtask

  task automatic test_reset;
    total++;
    if ({arvalid, rready, awvalid, wvalid, bready, out_valid, err} !== 7'd0 || rdata !== 32'd0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_initial: valids=%b rdata=%h in_ready=%b required all 0 and in_ready=1",
                      {arvalid, rready, awvalid, wvalid, bready, out_valid, err}, rdata, in_ready);
    end
    @(negedge clk);
    in_valid = 1; ren = 1; wen = 0; size = 2'd2; is_signed = 0; addr = 32'h8000_0010; wdata = 0;
    @(negedge clk);
    in_valid = 0; ren = 0; arready = 1;
    @(negedge clk);
    arready = 0;
    total++;
    if (rready !== 1'b1) begin
      bad++; $display("FAIL reset_reach_rdata: rready=%b required 1", rready);
    end
    rst = 0;
    repeat (2) @(negedge clk);
    total++;
    if ({arvalid, rready, awvalid, wvalid, bready, out_valid, err} !== 7'd0 || rdata !== 32'd0) begin
      bad++; $display("FAIL reset_mid_rdata: valids=%b rdata=%h required 0",
                      {arvalid, rready, awvalid, wvalid, bready, out_valid, err}, rdata);
    end
    rst = 1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || rready !== 1'b0 || arvalid !== 1'b0) begin
      bad++; $display("FAIL reset_release: in_ready=%b out_valid=%b rready=%b arvalid=%b required 1/0/0/0",
                      in_ready, out_valid, rready, arvalid);
    end
  endtask

  task automatic test_load_byte_signed;
    run_op(1, 0, 2'b00, 1, 32'h8000_0003, 32'd0, 32'h80FF_1234, 2'b00, 0, 0, 0, 0, 0, 0);
    total++;
    if (obs_araddr !== 32'h8000_0000) begin bad++; $display("FAIL lb_araddr: got %h want 80000000", obs_araddr); end
    total++;
    if (obs_rdata !== 32'hFFFF_FF80 || obs_err !== 1'b0) begin
      bad++; $display("FAIL lb_rdata: got %h err=%b want ffffff80 err=0", obs_rdata, obs_err);
    end
    total++;
    if (obs_lat !== 3 || obs_accept !== 1'b1) begin
      bad++; $display("FAIL lb_latency: got %0d accept=%b want 3 accept=1", obs_lat, obs_accept);
    end
  endtask

  task automatic test_load_half_unsigned;
    run_op(1, 0, 2'b01, 0, 32'h8000_0002, 32'd0, 32'hBEEF_0000, 2'b00, 1, 2, 0, 0, 0, 0);
    total++;
    if (obs_rdata !== 32'h0000_BEEF || obs_err !== 1'b0) begin
      bad++; $display("FAIL lhu_rdata: got %h err=%b want 0000beef err=0", obs_rdata, obs_err);
    end
    total++;
    if (obs_lat !== 6 || obs_unstable !== 0) begin
      bad++; $display("FAIL lhu_timing: lat=%0d unstable=%0d want 6 and 0", obs_lat, obs_unstable);
    end
  endtask

  task automatic test_store_half;
    run_op(0, 1, 2'b01, 0, 32'h8000_0006, 32'h0000_ABCD, 32'd0, 2'b00, 0, 0, 3, 0, 0, 0);
    total++;
    if (obs_wstrb !== 4'b1100 || obs_wdata_bus !== 32'hABCD_0000 || obs_awaddr !== 32'h8000_0004) begin
      bad++; $display("FAIL sh_bus: wstrb=%b wdata_bus=%h awaddr=%h want 1100 abcd0000 80000004",
                      obs_wstrb, obs_wdata_bus, obs_awaddr);
    end
    total++;
    if (obs_aw_hs !== 1 || obs_w_hs !== 1 || obs_b_hs !== 1) begin
      bad++; $display("FAIL sh_handshakes: aw=%0d w=%0d b=%0d want 1 1 1", obs_aw_hs, obs_w_hs, obs_b_hs);
    end
    total++;
    if (obs_lat !== 6 || obs_err !== 1'b0 || obs_rdata !== 32'd0 || obs_unstable !== 0) begin
      bad++; $display("FAIL sh_result: lat=%0d err=%b rdata=%h unstable=%0d want 6 0 0 0",
                      obs_lat, obs_err, obs_rdata, obs_unstable);
    end
  endtask

  task automatic test_faults;
    run_op(1, 0, 2'b10, 0, 32'h8000_0001, 32'd0, 32'h1234_5678, 2'b00, 0, 0, 0, 0, 0, 0);
    total++;
    if (obs_bus !== 1'b0 || obs_err !== 1'b1 || obs_lat !== 1 || obs_rdata !== 32'd0) begin
      bad++; $display("FAIL fault_misaligned: bus=%b err=%b lat=%0d rdata=%h want 0 1 1 0",
                      obs_bus, obs_err, obs_lat, obs_rdata);
    end
    run_op(0, 1, 2'b10, 0, 32'h8000_0008, 32'h1111_2222, 32'd0, 2'b10, 1, 0, 0, 1, 2, 0);
    total++;
    if (obs_err !== 1'b1 || obs_lat !== 6) begin
      bad++; $display("FAIL fault_bresp: err=%b lat=%0d want 1 6", obs_err, obs_lat);
    end
    run_op(0, 0, 2'b01, 0, 32'h8000_0003, 32'd0, 32'd0, 2'b00, 0, 0, 0, 0, 0, 0);
    total++;
    if (obs_bus !== 1'b0 || obs_err !== 1'b0 || obs_lat !== 1 || obs_rdata !== 32'd0) begin
      bad++; $display("FAIL noop: bus=%b err=%b lat=%0d rdata=%h want 0 0 1 0", obs_bus, obs_err, obs_lat, obs_rdata);
    end
  endtask

  task automatic test_backpressure;
    run_op(1, 0, 2'b00, 0, 32'h8000_0001, 32'd0, 32'h0000_A500, 2'b00, 0, 0, 0, 0, 0, 4);
    total++;
    if (obs_rdata !== 32'h0000_00A5 || obs_unstable !== 0) begin
      bad++; $display("FAIL bp_stable: rdata=%h unstable=%0d want 000000a5 0", obs_rdata, obs_unstable);
    end
    total++;
    if (obs_idle_after !== 1'b1 || obs_timeout !== 1'b0) begin
      bad++; $display("FAIL bp_idle_after: idle=%b timeout=%b want 1 0", obs_idle_after, obs_timeout);
    end
  endtask

  task automatic test_random;
    logic        r_ren, r_wen, r_sgn;
    logic [1:0]  r_size, r_resp;
    logic [31:0] r_addr, r_wd, r_bus;
    int          d[6];
    int          k, n;
    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 9);
      r_ren = (k <= 3) || (k == 8);
      r_wen = (k >= 4 && k <= 8);
      r_size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      r_sgn = 1'($urandom);
      r_addr = 32'h8000_0000 | ($urandom & 32'h0000_FFFF);
      n = (r_size == 2'd0) ? 1 : (r_size == 2'd1) ? 2 : 4;
      if ($urandom_range(0, 1) == 1) r_addr = r_addr - (r_addr % n);
      r_wd = $urandom; r_bus = $urandom;
      r_resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      foreach (d[j]) d[j] = $urandom_range(0, 3);
      model(r_ren, r_wen, r_size, r_sgn, r_addr, r_wd, r_bus, r_resp, d[0], d[1], d[2], d[3], d[4]);
      run_op(r_ren, r_wen, r_size, r_sgn, r_addr, r_wd, r_bus, r_resp, d[0], d[1], d[2], d[3], d[4], d[5]);
      total++;
      if (obs_timeout !== 1'b0 || obs_lat !== exp_lat) begin
        bad++; $display("FAIL rnd%0d_latency: lat=%0d timeout=%b want %0d", i, obs_lat, obs_timeout, exp_lat);
      end
      total++;
      if (obs_rdata !== exp_rdata || obs_err !== exp_err) begin
        bad++; $display("FAIL rnd%0d_result: rdata=%h err=%b want %h %b (ren=%b wen=%b size=%0d addr=%h)",
                        i, obs_rdata, obs_err, exp_rdata, exp_err, r_ren, r_wen, r_size, r_addr);
      end
      total++;
      if ({4'(obs_ar_hs), 4'(obs_r_hs), 4'(obs_aw_hs), 4'(obs_w_hs), 4'(obs_b_hs)} !== exp_hs) begin
        bad++; $display("FAIL rnd%0d_handshakes: ar=%0d r=%0d aw=%0d w=%0d b=%0d want %h",
                        i, obs_ar_hs, obs_r_hs, obs_aw_hs, obs_w_hs, obs_b_hs, exp_hs);
      end
      if (exp_hs[19:16] == 4'd1) begin
        total++;
        if (obs_araddr !== exp_addr) begin
          bad++; $display("FAIL rnd%0d_araddr: got %h want %h", i, obs_araddr, exp_addr);
        end
      end
      if (exp_hs[7:4] == 4'd1) begin
        total++;
        if (obs_awaddr !== exp_addr || obs_wdata_bus !== exp_wd || obs_wstrb !== exp_ws) begin
          bad++; $display("FAIL rnd%0d_store: awaddr=%h wdata_bus=%h wstrb=%b want %h %h %b",
                          i, obs_awaddr, obs_wdata_bus, obs_wstrb, exp_addr, exp_wd, exp_ws);
        end
      end
      total++;
      if (obs_unstable !== 0 || obs_idle_after !== 1'b1 || obs_accept !== 1'b1) begin
        bad++; $display("FAIL rnd%0d_protocol: unstable=%0d idle_after=%b accept=%b want 0 1 1",
                        i, obs_unstable, obs_idle_after, obs_accept);
      end
    end
  endtask

  initial begin
    rst = 0; in_valid = 0; ren = 0; wen = 0; size = 0; is_signed = 0; addr = 0; wdata = 0;
    clear_bus_inputs();
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    test_reset();
    test_load_byte_signed();
    test_load_half_unsigned();
    test_store_half();
    test_faults();
    test_backpressure();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
